// File: rtl/mux_srcaddr_seq_if.sv
// Address-source / exception-vector bus for mux_srcaddr_seq.
// slave: the address mux block. master: whoever drives selects and memory responses.
interface mux_srcaddr_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic [2:0]        sel;
  logic              addr_we;
  logic [DATA_W-1:0] iord_out;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              exc_req;
  logic [1:0]        exc_cause;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [DATA_W-1:0] addr_out;
  logic              busy;
  logic              vec_done;
  logic [DATA_W-1:0] handler_addr;
  logic              cause_err;

  modport slave (
    input  sel, addr_we, iord_out, a, b, exc_req, exc_cause, mem_ack, mem_rdata,
    output addr_out, busy, vec_done, handler_addr, cause_err
  );

  modport master (
    output sel, addr_we, iord_out, a, b, exc_req, exc_cause, mem_ack, mem_rdata,
    input  addr_out, busy, vec_done, handler_addr, cause_err
  );
endinterface

// File: rtl/mux_srcaddr_seq.sv
// Registered memory-address source mux with exception-vector sequencer.
// Optional feature macro: MUX_SRCADDR_AUTOINC_EN (sel 111 selects addr_out+INC_STEP;
// otherwise sel 111 selects 0).
module mux_srcaddr_seq #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned VEC_BASE = 253,
  parameter int unsigned NUM_VEC  = 3,
  parameter int unsigned INC_STEP = 4
) (
  input logic                clk,
  input logic                reset_n,
  mux_srcaddr_seq_if.slave   bus
);

  localparam logic [DATA_W-1:0] VEC_BASE_W = DATA_W'(VEC_BASE);
  localparam logic [2:0]        NUM_VEC_W  = 3'(NUM_VEC);

  // Reject parameter sets the datapath cannot represent.
  if (NUM_VEC < 1 || NUM_VEC > 4 || DATA_W < 8 || INC_STEP == 0) begin : g_param_chk
    $error("mux_srcaddr_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VEC  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] handler_q;
  logic              busy_q;
  logic              vec_done_q;
  logic              cause_err_q;

  logic [DATA_W-1:0] src_c;
  logic [1:0]        vidx_c;
  logic              cause_ok_c;

  assign vidx_c     = 2'(bus.sel[1:0] - 2'd1);
  assign cause_ok_c = ({1'b0, bus.exc_cause} < NUM_VEC_W);

  // Decode the selected address source.
  always_comb begin
    src_c = '0;
    unique case (bus.sel)
      3'b000:                src_c = bus.iord_out;
      3'b001, 3'b010, 3'b011: begin
        if ({1'b0, vidx_c} < NUM_VEC_W) begin
          src_c = VEC_BASE_W + DATA_W'(vidx_c);
        end
      end
      3'b100:                src_c = '0;
      3'b101:                src_c = bus.a;
      3'b110:                src_c = bus.b;
      3'b111: begin
`ifdef MUX_SRCADDR_AUTOINC_EN
        src_c = addr_q + DATA_W'(INC_STEP);
`else
        src_c = '0;
`endif
      end
      default:               src_c = '0;
    endcase
  end

  // Sequencer state, address register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      handler_q   <= '0;
      busy_q      <= 1'b0;
      vec_done_q  <= 1'b0;
      cause_err_q <= 1'b0;
    end else begin
      vec_done_q  <= 1'b0;
      cause_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.exc_req && cause_ok_c) begin
            // Exception wins over a normal load in the same cycle.
            state  <= VEC;
            addr_q <= VEC_BASE_W + DATA_W'(bus.exc_cause);
            busy_q <= 1'b1;
          end else begin
            if (bus.exc_req) begin
              cause_err_q <= 1'b1;
            end
            if (bus.addr_we) begin
              addr_q <= src_c;
            end
          end
        end
        VEC: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mem_ack) begin
            state      <= DONE;
            handler_q  <= DATA_W'(bus.mem_rdata);
            vec_done_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.addr_out     = addr_q;
  assign bus.handler_addr = handler_q;
  assign bus.busy         = busy_q;
  assign bus.vec_done     = vec_done_q;
  assign bus.cause_err    = cause_err_q;

endmodule

// File: tb/tb_mux_srcaddr_seq.sv
// Self-checking bench for mux_srcaddr_seq: directed steps plus random traffic
// against a behavioural model.
module tb_mux_srcaddr_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned VB = 253;
  localparam int unsigned NV = 3;
  localparam int unsigned IS = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mux_srcaddr_seq_if #(.DATA_W(DW)) bus ();

  mux_srcaddr_seq #(
    .DATA_W(DW), .VEC_BASE(VB), .NUM_VEC(NV), .INC_STEP(IS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: sequence position counted in cycles since the request.
  logic [31:0] m_addr, m_handler;
  logic        m_busy, m_done, m_cerr;
  int          m_seq;   // -1 not in a sequence; 0 just accepted; 1 waiting for memory; 2 finishing
  int          vec_done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_handler = 0; m_busy = 0; m_done = 0; m_cerr = 0; m_seq = -1;
  endtask

  function automatic logic [31:0] pick_source(input logic [2:0] s);
    int unsigned v;
    v = s;
    if (v == 0) return bus.iord_out;
    if (v >= 1 && v <= 3) return (v - 1 < NV) ? 32'(VB + v - 1) : 32'd0;
    if (v == 5) return bus.a;
    if (v == 6) return bus.b;
`ifdef MUX_SRCADDR_AUTOINC_EN
    if (v == 7) return m_addr + 32'(IS);
`endif
    return 32'd0;
  endfunction

  task automatic model_edge();
    m_done = 0;
    m_cerr = 0;
    if (m_seq < 0) begin
      if (bus.exc_req && int'(bus.exc_cause) < int'(NV)) begin
        m_addr = 32'(VB + bus.exc_cause);
        m_busy = 1;
        m_seq  = 0;
      end else begin
        if (bus.exc_req) m_cerr = 1;
        if (bus.addr_we) m_addr = pick_source(bus.sel);
      end
    end else if (m_seq == 0) begin
      m_seq = 1;
    end else if (m_seq == 1) begin
      if (bus.mem_ack) begin
        m_handler = {24'd0, bus.mem_rdata};
        m_done = 1;
        m_busy = 0;
        m_seq  = 2;
      end
    end else begin
      m_seq = -1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr_out"},     bus.addr_out,            m_addr);
    chk({tag, ".handler_addr"}, bus.handler_addr,        m_handler);
    chk({tag, ".busy"},         32'(bus.busy),           32'(m_busy));
    chk({tag, ".vec_done"},     32'(bus.vec_done),       32'(m_done));
    chk({tag, ".cause_err"},    32'(bus.cause_err),      32'(m_cerr));
  endtask

  // One clock: model advances with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    if (bus.vec_done === 1'b1) vec_done_cnt++;
    check_all(tag);
  endtask

  task automatic drive(input logic [2:0] s, input logic we, input logic er,
                       input logic [1:0] ec, input logic ack, input logic [7:0] rd);
    bus.sel = s; bus.addr_we = we; bus.exc_req = er; bus.exc_cause = ec;
    bus.mem_ack = ack; bus.mem_rdata = rd;
  endtask

  task automatic idle_inputs();
    drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.iord_out = 32'h0000_0040;
    bus.a = 32'h0000_1000;
    bus.b = 32'h0000_0020;
    idle_inputs();
    model_reset();

    // Reset state
    #12;
    check_all("reset");
    chk("reset_addr", bus.addr_out, 32'd0);
    reset_n = 1'b1;
    #2;

    // Load from A, then B without write enable
    drive(3'b101, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
    step("load_a");
    chk("load_a_const", bus.addr_out, 32'h1000);
    drive(3'b110, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    step("hold_b");
    chk("hold_b_const", bus.addr_out, 32'h1000);

    // Vector constants and zero
    for (int s = 1; s <= 4; s++) begin
      drive(3'(s), 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
      step("const");
      chk("const_val", bus.addr_out, (s == 4) ? 32'd0 : 32'(252 + s));
    end
    drive(3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
    step("load_iord");

    // Exception sequence, cause 2, memory slow for 3 cycles
    drive(3'b000, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00);
    step("exc_start");
    chk("exc_vec_addr", bus.addr_out, 32'd255);
    chk("exc_busy", 32'(bus.busy), 32'd1);
    drive(3'b101, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11);   // ignored while busy, ack outside WAIT
    step("exc_vec");
    drive(3'b101, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("exc_wait");
    chk("exc_wait_addr", bus.addr_out, 32'd255);
    drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 8'h8C);
    step("exc_ack");
    chk("exc_handler", bus.handler_addr, 32'h0000_008C);
    chk("exc_done", 32'(bus.vec_done), 32'd1);
    chk("exc_busy_off", 32'(bus.busy), 32'd0);
    idle_inputs();
    step("exc_end");
    chk("exc_done_pulse", 32'(bus.vec_done), 32'd0);
    chk("exc_addr_kept", bus.addr_out, 32'd255);

    // Exception and load in the same idle cycle: vector wins
    drive(3'b101, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00);
    step("prio");
    chk("prio_addr", bus.addr_out, 32'd253);
    idle_inputs();
    step("prio_vec");
    drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 8'h5A);
    step("prio_ack");
    idle_inputs();
    step("prio_done");

    // Bad cause: error pulse, load still honoured
    drive(3'b110, 1'b1, 1'b1, 2'd3, 1'b0, 8'h00);
    step("bad_cause");
    chk("bad_cause_err", 32'(bus.cause_err), 32'd1);
    chk("bad_cause_busy", 32'(bus.busy), 32'd0);
    chk("bad_cause_load", bus.addr_out, 32'h20);
    idle_inputs();
    step("bad_cause_clr");

    // Reset asserted while waiting for memory
    drive(3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00);
    step("rst_seq0");
    idle_inputs();
    step("rst_seq1");
    step("rst_seq2");
    vec_done_cnt = 0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'hEE;
    step("rst_held");
    reset_n = 1'b1;
    idle_inputs();
    step("rst_after");
    chk("rst_no_done", 32'(vec_done_cnt), 32'd0);

    // sel 111 from the top of the address space
    bus.a = 32'hFFFF_FFFC;
    drive(3'b101, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
    step("inc_pre");
    drive(3'b111, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00);
    step("inc1");
`ifdef MUX_SRCADDR_AUTOINC_EN
    chk("inc1_wrap", bus.addr_out, 32'h0000_0000);
    step("inc2");
    chk("inc2_val", bus.addr_out, 32'h0000_0004);
`else
    chk("sel7_zero", bus.addr_out, 32'h0000_0000);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.iord_out = $urandom;
      bus.a = $urandom;
      bus.b = $urandom;
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0), 8'($urandom));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
